// File: rtl/uart_rx.sv
// 8N1 serial receiver with a flag-style holding buffer (READY/OVERRUN/FERR) polled and cleared by CLR.
// Byte reported on the stop-sample edge, 2+HALF+9*CLKS_PER_BIT cycles after the start edge; no backpressure, newest byte overwrites.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10400
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  input  logic       CLR,
  output logic [7:0] DATA,
  output logic       READY,
  output logic       OVERRUN,
  output logic       FERR,
  output logic       BUSY
);

  // CLKS_PER_BIT must be at least 4 so that HALF-1 is a valid, nonzero count.
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q;
  logic [1:0]    sync_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], RX};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      // Registered so BUSY rises one cycle after START is entered.
      busy_q  <= (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;

    // CLR is applied first so a completing frame on the same edge overrides it.
    if (CLR) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bitn_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bitn_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            ready_d = 1'b1;
            // A simultaneous CLR means the previous byte was consumed.
            ovr_d   = ovr_d | (ready_q & ~CLR);
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        cnt_d  = '0;
        bitn_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bitn_d  = '0;
      end
    endcase
  end

  assign DATA    = data_q;
  assign READY   = ready_q;
  assign OVERRUN = ovr_q;
  assign FERR    = ferr_q;
  assign BUSY    = busy_q;

endmodule
